raw_capture: RTL and testbench

Sensor-side capture stage feeding the RAW-to-RGB stage. Samples the camera's frame_valid/line_valid/pixel bus, arms and disarms on start/stop commands, and emits one Bayer RAW pixel per accepted sensor pixel. Each pixel carries 12-bit x/y coordinates and is cropped to a programmable window. A one-cycle done pulse is raised at the end of each captured frame.

---
 rtl/raw_capture_if.sv | 28 ++
 rtl/raw_capture.sv | 180 ++++++++++++++++++
 tb/tb_raw_capture.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/raw_capture_if.sv
// rtl/raw_capture_if.sv - captured pixel stream between raw_capture and the RAW-to-RGB stage
interface raw_capture_if #(
  parameter int N = 8
) ();
  logic         out_valid;
  logic [N-1:0] out_data;
  logic [11:0]  out_x;
  logic [11:0]  out_y;
  logic         out_done;

  // Producer side: the capture stage drives the pixel stream.
  modport master (
    output out_valid,
    output out_data,
    output out_x,
    output out_y,
    output out_done
  );

  // Consumer side: the downstream stage, which accepts every strobe.
  modport slave (
    input out_valid,
    input out_data,
    input out_x,
    input out_y,
    input out_done
  );
endinterface

// File: rtl/raw_capture.sv
// rtl/raw_capture.sv - sensor capture with arm/disarm, x/y tagging, crop window and frame done
module raw_capture #(
  parameter int N       = 8,
  parameter int IN_BITS = 12
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [11:0]        width,
  input  logic [11:0]        height,
  input  logic               start,
  input  logic               stop,
  input  logic               in_frame_valid,
  input  logic               in_line_valid,
  input  logic [IN_BITS-1:0] in_data,
  raw_capture_if.master      pix,
  output logic               busy,
  output logic [31:0]        frame_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE
  } state_t;

  state_t             state_q, state_d;
  logic               run_q, run_d;
  logic               fv1_q, lv1_q;
  logic               fv2_q, lv2_q;
  logic [IN_BITS-1:0] d1_q;
  logic [11:0]        x_q, x_d, y_q, y_d;
  logic [11:0]        w_q, w_d, h_q, h_d;
  logic               ov_q, ov_d;
  logic [N-1:0]       od_q, od_d;
  logic [11:0]        ox_q, ox_d, oy_q, oy_d;
  logic               done_q, done_d;
  logic [31:0]        fc_q, fc_d;

  logic fv_rise, fv_fall, lv_fall, sensor_pixel;

  // Edges are taken between the stage-1 sample and the one before it.
  assign fv_rise      = fv1_q & ~fv2_q;
  assign fv_fall      = ~fv1_q & fv2_q;
  assign lv_fall      = ~lv1_q & lv2_q;
  assign sensor_pixel = fv1_q & lv1_q;

  // Only the top N sensor bits travel downstream; the rest are sampled but dropped.
  generate
    if (IN_BITS > N) begin : g_lsb
      logic unused_lsb;
      assign unused_lsb = ^d1_q[IN_BITS-N-1:0];
    end
  endgenerate

  // Stage-1 sensor sampling plus the previous sample used for edge detection.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      fv1_q <= 1'b0;
      lv1_q <= 1'b0;
      d1_q  <= '0;
      fv2_q <= 1'b0;
      lv2_q <= 1'b0;
    end else begin
      fv1_q <= in_frame_valid;
      lv1_q <= in_line_valid;
      d1_q  <= in_data;
      fv2_q <= fv1_q;
      lv2_q <= lv1_q;
    end
  end

  // Next-state logic: run flag, capture FSM, coordinate counters and output stage.
  always_comb begin
    run_d   = run_q;
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    w_d     = w_q;
    h_d     = h_q;
    ov_d    = 1'b0;
    od_d    = od_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    done_d  = 1'b0;
    fc_d    = fc_q;

    // stop has priority so a simultaneous start/stop leaves the block disarmed.
    if (stop) begin
      run_d = 1'b0;
    end else if (start) begin
      run_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (run_d) begin
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        // A frame already in progress never produces a rising edge, so it is skipped.
        if (!run_d) begin
          state_d = S_IDLE;
        end else if (fv_rise) begin
          w_d     = width;
          h_d     = height;
          x_d     = '0;
          y_d     = '0;
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (sensor_pixel) begin
          if ((x_q < w_q) && (y_q < h_q)) begin
            ov_d = 1'b1;
            od_d = d1_q[IN_BITS-1 -: N];
            ox_d = x_q;
            oy_d = y_q;
          end
          if (x_q != 12'hFFF) begin
            x_d = x_q + 12'd1;
          end
        end
        if (lv_fall) begin
          x_d = '0;
          if (y_q != 12'hFFF) begin
            y_d = y_q + 12'd1;
          end
        end
        // A stop during the frame only takes effect here, once the frame is complete.
        if (fv_fall) begin
          done_d  = 1'b1;
          fc_d    = fc_q + 32'd1;
          state_d = run_d ? S_ARMED : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output register bank.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      run_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      done_q  <= 1'b0;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      x_q     <= x_d;
      y_q     <= y_d;
      w_q     <= w_d;
      h_q     <= h_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      done_q  <= done_d;
      fc_q    <= fc_d;
    end
  end

  assign pix.out_valid = ov_q;
  assign pix.out_data  = od_q;
  assign pix.out_x     = ox_q;
  assign pix.out_y     = oy_q;
  assign pix.out_done  = done_q;
  assign busy          = (state_q != S_IDLE);
  assign frame_count   = fc_q;

endmodule

// File: tb/tb_raw_capture.sv
// tb/tb_raw_capture.sv - directed vector bench for raw_capture
module tb_raw_capture;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [11:0] width, height;
  logic        start, stop;
  logic        in_frame_valid, in_line_valid;
  logic [11:0] in_data;
  logic        busy;
  logic [31:0] frame_count;

  raw_capture_if #(.N(8)) pix ();

  raw_capture #(.N(8), .IN_BITS(12)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .width          (width),
    .height         (height),
    .start          (start),
    .stop           (stop),
    .in_frame_valid (in_frame_valid),
    .in_line_valid  (in_line_valid),
    .in_data        (in_data),
    .pix            (pix),
    .busy           (busy),
    .frame_count    (frame_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  d;
    logic [11:0] x;
    logic [11:0] y;
    int          cyc;
  } pix_t;

  typedef struct {
    int w, h, lines, npix, exp_cnt, exp_x, exp_y;
  } row_t;

  int     checks = 0;
  int     failures = 0;
  int     cyc = 0;
  pix_t   log_q[$];
  pix_t   ent;
  int     done_cnt = 0;
  int     done_cyc = 0;
  logic   busy_at_done = 1'b0;
  int     first_cyc, fv_low_cyc;
  int     b0, d0, n, exp_fc;
  row_t   rows[5];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Output monitor, sampled 1 time unit after the active edge.
  always @(posedge clock) begin
    #1;
    if (pix.out_valid === 1'b1) begin
      ent.d   = pix.out_data;
      ent.x   = pix.out_x;
      ent.y   = pix.out_y;
      ent.cyc = cyc;
      log_q.push_back(ent);
    end
    if (pix.out_done === 1'b1) begin
      done_cnt++;
      done_cyc     = cyc;
      busy_at_done = busy;
      check("done_without_valid", {31'd0, pix.out_valid}, 32'd0);
    end
  end

  task automatic step;
    @(negedge clock);
  endtask

  task automatic snap;
    b0 = log_q.size();
    d0 = done_cnt;
  endtask

  // One sensor frame; optional start/stop pulse in the blanking before a given line.
  task automatic send_frame(input int nlines, input int npix, input int base,
                            input int stop_line, input int start_line);
    int v;
    v = base;
    in_frame_valid = 1'b1;
    step();
    for (int l = 0; l < nlines; l++) begin
      if (l == stop_line) stop = 1'b1;
      if (l == start_line) start = 1'b1;
      step();
      stop  = 1'b0;
      start = 1'b0;
      in_line_valid = 1'b1;
      for (int p = 0; p < npix; p++) begin
        in_data = v[11:0];
        if (l == 0 && p == 0) first_cyc = cyc;
        v++;
        step();
      end
      in_line_valid = 1'b0;
      step();
      step();
    end
    in_frame_valid = 1'b0;
    fv_low_cyc = cyc;
    for (int i = 0; i < 4; i++) step();
  endtask

  initial begin
    rows[0] = '{2, 1, 3, 4, 2, 1, 0};
    rows[1] = '{3, 3, 2, 5, 6, 2, 1};
    rows[2] = '{0, 2, 2, 4, 0, 0, 0};
    rows[3] = '{5, 0, 2, 4, 0, 0, 0};
    rows[4] = '{10, 10, 2, 3, 6, 2, 1};

    reset_n = 1'b0; width = 12'd4; height = 12'd2; start = 1'b0; stop = 1'b0;
    in_frame_valid = 1'b0; in_line_valid = 1'b0; in_data = 12'd0;
    step();
    step();
    check("rst_valid", {31'd0, pix.out_valid}, 0);
    check("rst_done", {31'd0, pix.out_done}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_data", {24'd0, pix.out_data}, 0);
    check("rst_x", {20'd0, pix.out_x}, 0);
    check("rst_y", {20'd0, pix.out_y}, 0);
    check("rst_fc", frame_count, 0);
    reset_n = 1'b1;
    step();

    // Basic frame: 2 lines x 4 pixels, values 0x010..0x017.
    exp_fc = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("basic_busy_rise", {31'd0, busy}, 1);
    snap();
    send_frame(2, 4, 'h010, -1, -1);
    exp_fc++;
    n = log_q.size() - b0;
    check("basic_count", n, 8);
    for (int i = 0; i < 8 && i < n; i++) begin
      check("basic_data", {24'd0, log_q[b0+i].d}, 32'h01);
      check("basic_x", {20'd0, log_q[b0+i].x}, i % 4);
      check("basic_y", {20'd0, log_q[b0+i].y}, i / 4);
    end
    if (n > 0) check("basic_latency", log_q[b0].cyc, first_cyc + 2);
    check("basic_done_cnt", done_cnt - d0, 1);
    check("basic_done_latency", done_cyc, fv_low_cyc + 2);
    check("basic_fc", frame_count, exp_fc);
    check("basic_hold_x", {20'd0, pix.out_x}, 3);
    check("basic_hold_y", {20'd0, pix.out_y}, 1);
    check("basic_busy_rearmed", {31'd0, busy}, 1);

    // Crop/window table, captured back to back while armed.
    for (int r = 0; r < 5; r++) begin
      width  = rows[r].w[11:0];
      height = rows[r].h[11:0];
      snap();
      send_frame(rows[r].lines, rows[r].npix, 'h200 + 16 * r, -1, -1);
      exp_fc++;
      n = log_q.size() - b0;
      check($sformatf("row%0d_count", r), n, rows[r].exp_cnt);
      check($sformatf("row%0d_done", r), done_cnt - d0, 1);
      check($sformatf("row%0d_fc", r), frame_count, exp_fc);
      if (rows[r].exp_cnt > 0 && n > 0) begin
        check($sformatf("row%0d_last_x", r), {20'd0, log_q[b0+n-1].x}, rows[r].exp_x);
        check($sformatf("row%0d_last_y", r), {20'd0, log_q[b0+n-1].y}, rows[r].exp_y);
      end
    end

    // Stop during line 1: frame completes, then capture ends.
    width = 12'd4; height = 12'd2;
    snap();
    send_frame(2, 4, 'hAB0, 1, -1);
    exp_fc++;
    n = log_q.size() - b0;
    check("stop_count", n, 8);
    if (n > 0) check("stop_data", {24'd0, log_q[b0].d}, 32'hAB);
    check("stop_done", done_cnt - d0, 1);
    check("stop_busy_at_done", {31'd0, busy_at_done}, 0);
    check("stop_busy_after", {31'd0, busy}, 0);
    snap();
    send_frame(2, 4, 'h300, -1, -1);
    check("stop_next_count", log_q.size() - b0, 0);
    check("stop_next_done", done_cnt - d0, 0);
    check("stop_fc", frame_count, exp_fc);

    // Start mid-frame: that frame is skipped, the next one is captured.
    snap();
    send_frame(2, 4, 'h100, -1, 0);
    check("skip_count", log_q.size() - b0, 0);
    check("skip_done", done_cnt - d0, 0);
    check("skip_busy", {31'd0, busy}, 1);
    snap();
    send_frame(2, 4, 'h7FC, -1, -1);
    exp_fc++;
    n = log_q.size() - b0;
    check("skip_next_count", n, 8);
    if (n == 8) begin
      check("skip_data0", {24'd0, log_q[b0].d}, 32'h7F);
      check("skip_data7", {24'd0, log_q[b0+7].d}, 32'h80);
      check("skip_x7", {20'd0, log_q[b0+7].x}, 3);
      check("skip_y7", {20'd0, log_q[b0+7].y}, 1);
    end
    check("skip_fc", frame_count, exp_fc);

    // Stop while armed drops busy on the next cycle.
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("armed_stop_busy", {31'd0, busy}, 0);

    // Simultaneous start and stop from idle: stop wins.
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check("ss_busy0", {31'd0, busy}, 0);
    step();
    check("ss_busy1", {31'd0, busy}, 0);
    snap();
    send_frame(1, 3, 'h050, -1, -1);
    check("ss_count", log_q.size() - b0, 0);
    check("ss_done", done_cnt - d0, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("ss_start_busy", {31'd0, busy}, 1);
    snap();
    send_frame(1, 3, 'h050, -1, -1);
    exp_fc++;
    check("ss_cap_count", log_q.size() - b0, 3);
    check("ss_cap_fc", frame_count, exp_fc);

    // Reset for one cycle during line 0.
    in_frame_valid = 1'b1;
    step();
    step();
    in_line_valid = 1'b1;
    in_data = 12'h5A0;
    step();
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("mid_rst_valid", {31'd0, pix.out_valid}, 0);
    check("mid_rst_done", {31'd0, pix.out_done}, 0);
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_data", {24'd0, pix.out_data}, 0);
    check("mid_rst_x", {20'd0, pix.out_x}, 0);
    check("mid_rst_y", {20'd0, pix.out_y}, 0);
    check("mid_rst_fc", frame_count, 0);
    snap();
    step();
    step();
    in_line_valid = 1'b0;
    step();
    in_frame_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    send_frame(2, 4, 'h600, -1, -1);
    check("post_rst_count", log_q.size() - b0, 0);
    check("post_rst_done", done_cnt - d0, 0);
    check("post_rst_fc", frame_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
